// File: rtl/add_fsm_multi_pkg.sv
// Shared definitions for the multi-mode three-step add worker.
//   state_t     : FSM state encoding (IDLE, SUM, OFFS, FINAL)
//   MODE_*      : operation-select encodings captured with the operands
package add_fsm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SUM   = 2'd1,
    OFFS  = 2'd2,
    FINAL = 2'd3
  } state_t;

  localparam logic [1:0] MODE_LEGACY = 2'b00;  // R = x + y = 2(a+b) + K
  localparam logic [1:0] MODE_SUM    = 2'b01;  // R = x     = a + b
  localparam logic [1:0] MODE_SUM_K  = 2'b10;  // R = y     = a + b + K
  localparam logic [1:0] MODE_DOUBLE = 2'b11;  // R = x + x = 2(a+b)

endpackage

// File: rtl/add_fsm_multi.sv
// Multi-mode three-step add worker behind a go/done handshake.
// On an accepted go the operands and mode are captured, then the datapath
// runs sum -> offset -> combine, one registered step per clock.
// Ports:
//   CLK      in   rising-edge clock
//   reset_n  in   synchronous active-low reset
//   go       in   start request, honoured only in IDLE
//   mode     in   operation select, captured with the operands
//   a, b     in   WIDTH-bit operands
//   result   out  registered result modulo 2^WIDTH, held until next completion
//   ovf      out  true result did not fit in WIDTH bits
//   busy     out  high in every state except IDLE
//   done     out  one-cycle pulse in the cycle after result/ovf update
module add_fsm_multi
  import add_fsm_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int K     = 3
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             go,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  // Three guard bits: the largest value, 2(a+b)+K, stays below 8*2^WIDTH.
  localparam int XW = WIDTH + 3;

  state_t           state, state_next;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       mode_q;
  logic [XW-1:0]    x, y;
  logic [XW-1:0]    r_full;

  function automatic logic [XW-1:0] select_r(input logic [1:0]    m,
                                             input logic [XW-1:0] xv,
                                             input logic [XW-1:0] yv);
    logic [XW-1:0] r;
    case (m)
      MODE_LEGACY: r = xv + yv;
      MODE_SUM:    r = xv;
      MODE_SUM_K:  r = yv;
      default:     r = xv + xv;
    endcase
    return r;
  endfunction

  assign r_full = select_r(mode_q, x, y);
  assign busy   = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = SUM;
      SUM:     state_next = OFFS;
      OFFS:    state_next = FINAL;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!reset_n) begin
      a_q    <= '0;
      b_q    <= '0;
      mode_q <= '0;
      x      <= '0;
      y      <= '0;
      result <= '0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        // capture: operands and mode are frozen for the whole operation
        IDLE: begin
          if (go) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
          end
        end
        // step 1: full-precision sum
        SUM: x <= XW'(a_q) + XW'(b_q);
        // step 2: constant offset
        OFFS: y <= x + XW'(K);
        // step 3: mode-selected combine, truncated only here
        default: begin
          result <= r_full[WIDTH-1:0];
          ovf    <= |r_full[XW-1:WIDTH];
          done   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add_fsm_multi.sv
// Directed bench for add_fsm_multi with WIDTH=6, K=3.
module tb_add_fsm_multi;

  logic       CLK;
  logic       reset_n;
  logic       go;
  logic [1:0] mode;
  logic [5:0] a, b;
  logic [5:0] result;
  logic       ovf, busy, done;

  int checks   = 0;
  int failures = 0;

  add_fsm_multi #(.WIDTH(6), .K(3)) dut (
    .CLK(CLK), .reset_n(reset_n), .go(go), .mode(mode), .a(a), .b(b),
    .result(result), .ovf(ovf), .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present an operation, check busy/done across the 3-cycle latency and the
  // result on the done cycle. Inputs are scrambled after acceptance to show
  // they are not re-sampled while busy. Returns in the done cycle.
  task automatic run_op(input string tag, input logic [5:0] av, input logic [5:0] bv,
                        input logic [1:0] mv, input logic [5:0] exp_r, input logic exp_o);
    @(negedge CLK);
    a = av; b = bv; mode = mv; go = 1'b1;
    tick();
    go = 1'b0; a = ~av; b = ~bv; mode = ~mv;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      check({tag, "_busy"}, 32'(busy), 32'd1);
      check({tag, "_nodone"}, 32'(done), 32'd0);
    end
    tick();
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_result"}, 32'(result), 32'(exp_r));
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_o));
  endtask

  initial begin
    reset_n = 1'b0; go = 1'b0; mode = 2'b00; a = '0; b = '0;

    // reset held for two edges
    tick();
    tick();
    check("rst_result", 32'(result), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    @(negedge CLK);
    reset_n = 1'b1;

    // legacy: 2*(5+7)+3 = 27
    run_op("legacy", 6'd5, 6'd7, 2'b00, 6'd27, 1'b0);
    tick();
    check("legacy_done_clear", 32'(done), 32'd0);
    check("legacy_hold", 32'(result), 32'd27);

    // legacy overflow: 2*126+3 = 255 -> 63, ovf
    run_op("leg_ovf", 6'd63, 6'd63, 2'b00, 6'd63, 1'b1);
    // back-to-back from the done cycle: 1+1 = 2
    run_op("sum_small", 6'd1, 6'd1, 2'b01, 6'd2, 1'b0);

    // modes
    run_op("mode_sum", 6'd40, 6'd30, 2'b01, 6'd6, 1'b1);    // 70
    run_op("mode_sumk", 6'd10, 6'd20, 2'b10, 6'd33, 1'b0);  // 33
    run_op("mode_dbl", 6'd20, 6'd11, 2'b11, 6'd62, 1'b0);   // 62

    // busy rejection: go held high with new operands while busy
    @(negedge CLK);
    a = 6'd1; b = 6'd2; mode = 2'b00; go = 1'b1;
    tick();
    a = 6'd50; b = 6'd50;
    check("rej_busy0", 32'(busy), 32'd1);
    tick();
    check("rej_busy1", 32'(busy), 32'd1);
    tick();
    check("rej_busy2", 32'(busy), 32'd1);
    tick();
    check("rej_done", 32'(done), 32'd1);
    check("rej_result", 32'(result), 32'd9);
    check("rej_ovf", 32'(ovf), 32'd0);
    // go still high in the done cycle: second op accepted here
    tick();
    go = 1'b0;
    check("rej2_busy", 32'(busy), 32'd1);
    check("rej2_nodone", 32'(done), 32'd0);
    tick();
    tick();
    tick();
    check("rej2_done", 32'(done), 32'd1);
    check("rej2_result", 32'(result), 32'd11);  // 203 mod 64
    check("rej2_ovf", 32'(ovf), 32'd1);

    // reset mid-operation, asserted while in OFFS
    @(negedge CLK);
    a = 6'd5; b = 6'd7; mode = 2'b00; go = 1'b1;
    tick();           // accepted -> SUM
    go = 1'b0;
    tick();           // -> OFFS
    check("midrst_busy_before", 32'(busy), 32'd1);
    reset_n = 1'b0;
    tick();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_ovf", 32'(ovf), 32'd0);
    @(negedge CLK);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_no_done", 32'(done), 32'd0);
      check("midrst_idle", 32'(busy), 32'd0);
    end
    run_op("after_rst", 6'd5, 6'd7, 2'b00, 6'd27, 1'b0);

    // idle stability after a fresh reset
    @(negedge CLK);
    reset_n = 1'b0;
    tick();
    @(negedge CLK);
    reset_n = 1'b1; go = 1'b0; a = 6'd33; b = 6'd44; mode = 2'b11;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_result", 32'(result), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_fsm_multi.md
Name: add_fsm_multi

Overview:
- Parametrised, multi-mode successor to the team's 6-bit three-step add FSM.
- On a `go` request it captures two WIDTH-bit operands and runs a fixed 3-step datapath: sum, offset, combine.
- Returns a WIDTH-bit result with an overflow flag, a `busy` status and a one-cycle `done` pulse.
- Sits as a small arithmetic worker behind a simple go/done handshake in the problem-session datapath designs.

Parameters:
- WIDTH, 6, operand and result width in bits (≥2).
- K, 3, constant offset added in the offset step; must satisfy 0 ≤ K < 2^WIDTH.

Ports:
- CLK  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset, sampled on the CLK rising edge.
- go  input  1  start request; honoured only in IDLE.
- mode  input  2  operation select; captured with the operands.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- result  output  WIDTH  registered result, modulo 2^WIDTH; held until the next completion.
- ovf  output  1  set when the true result is ≥ 2^WIDTH; updated together with result.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse, high in the cycle after result/ovf update.

Behaviour:
- Reset: when reset_n=0 at an edge:
  - state goes to IDLE.
  - result=0, ovf=0, done=0, busy=0.
  - internal a_q, b_q, mode_q, x, y are cleared to 0.
  - Reset mid-operation aborts with no done pulse, and result/ovf are cleared.
- States and transitions: IDLE → SUM → OFFS → FINAL → IDLE.
- Edge in IDLE with go=1:
  - capture a_q=a, b_q=b, mode_q=mode.
  - move to SUM.
  - go=0 stays in IDLE.
- Edge in SUM: x ← a_q+b_q, with no truncation; move to OFFS.
- Edge in OFFS: y ← x+K; move to FINAL.
- Edge in FINAL:
  - full-precision value R is chosen by mode_q:
    - 00 LEGACY: R = x+y = 2(a+b)+K.
    - 01 SUM: R = x.
    - 10 SUM_K: R = y.
    - 11 DOUBLE: R = x+x.
  - result ← R[WIDTH-1:0]; ovf ← (R ≥ 2^WIDTH); done ← 1; move to IDLE.
- Width rule: internal x, y and R are WIDTH+3 bits, so no intermediate ever wraps; truncation happens only at the output.
- Latency:
  - go accepted at edge E → result/ovf valid and done=1 after edge E+3.
  - busy=1 after edges E..E+2 and falls after edge E+3.
- done is high for exactly one cycle and is cleared at the next edge unless reset.
- go while busy=1 is ignored; it is neither queued nor captured, and operands changing while busy have no effect.
- Back-to-back: go=1 in the done cycle (state IDLE) is accepted, giving a sustained throughput of one operation per 4 cycles.
- mode is captured at acceptance; changes while busy do not affect the running operation.

Decomposition:
- Package add_fsm_pkg:
  - 2-bit state encodings: IDLE=0, SUM=1, OFFS=2, FINAL=3.
  - mode constants: MODE_LEGACY=2'b00, MODE_SUM=2'b01, MODE_SUM_K=2'b10, MODE_DOUBLE=2'b11.
- Single module; no sub-module is natural, as the datapath is three registered adds sharing one FSM.

Test Plan (WIDTH=6, K=3):
- Legacy: reset_n=0 for 2 cycles, then release; go with a=5, b=7, mode=00 → done exactly 3 edges after acceptance, result=27, ovf=0; busy high for 3 cycles.
- Legacy overflow: a=63, b=63, mode=00 (R=255) → result=63, ovf=1; next op a=1, b=1, mode=01 → result=2, ovf=0.
- Modes:
  - a=40, b=30, mode=01 → result=6, ovf=1.
  - a=10, b=20, mode=10 → result=33, ovf=0.
  - a=20, b=11, mode=11 → result=62, ovf=0.
- Busy rejection: accept a=1, b=2, mode=00; hold go=1 with a=50, b=50 during busy → result=9 only, then a second op starts in the done cycle and yields result=2·100+3 mod 64=11, ovf=1.
- Reset mid-op: accept a=5, b=7; drop reset_n in OFFS → no done pulse, result=0, ovf=0, busy=0, state IDLE; a fresh go completes normally.
- Idle stability: go=0 for 20 cycles after reset → busy=0, done=0 and result unchanged throughout.
